// File: rtl/parx_pkg.sv
// Shared definitions for the parx parity-framed serial link.
// Used by the transmitter today and by the receiver later, so it holds only
// line-level constants and the transmitter state encoding.
//   parx_tx_state_t : transmitter FSM states
//   PARX_START_BIT  : line level of the start bit
//   PARX_STOP_BIT   : line level of the stop bit
//   PARX_IDLE_LEVEL : line level when no frame is in flight
package parx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } parx_tx_state_t;

  localparam logic PARX_START_BIT  = 1'b0;
  localparam logic PARX_STOP_BIT   = 1'b1;
  localparam logic PARX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parx_serial_tx_if.sv
// Valid/ready word handshake into the parx serial transmitter.
//   in_data  : word to transmit, sampled on the handshake cycle
//   in_valid : in_data is valid
//   in_ready : transmitter can accept a word this cycle
// master = word producer, slave = transmitter.
interface parx_serial_tx_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/parx_bit_timer.sv
// Bit-time generator for the parx transmitter.
//   clk      : clock
//   rst      : synchronous active-high reset
//   restart  : realign the count so the next cycle is the first of a bit time
//   bit_done : high on the last cycle of every CLKS_PER_BIT-cycle bit time
// The counter free-runs 0..CLKS_PER_BIT-1; the FSM restarts it on the
// handshake so the start bit is exactly CLKS_PER_BIT cycles long.
module parx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_done = (cnt_q == LAST);

endmodule

// File: rtl/parx_serial_tx.sv
// Serial frame transmitter for the parx link.
// Frame on tx: start(0), DATA_W data bits LSB first, parity, stop(1); each
// bit held CLKS_PER_BIT cycles. Parity is even (PARITY_ODD=0) or odd (=1).
//   clk         : clock
//   rst         : synchronous active-high reset, aborts any frame in flight
//   in_if       : valid/ready word input (slave side)
//   tx          : serial line, idle high, registered
//   busy        : frame in progress (any state other than IDLE)
//   frames_sent : completed frames, wraps 255 -> 0
// All outputs are registered: the handshake in cycle N shows tx low and busy
// high in cycle N+1.
module parx_serial_tx
  import parx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  parx_serial_tx_if.slave        in_if,
  output logic                   tx,
  output logic                   busy,
  output logic [7:0]             frames_sent
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  parx_tx_state_t    state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_shifted;
  logic              parity_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              in_ready_q;
  logic              accept;
  logic              bit_done;

  // in_ready_q is only high in IDLE, so accept implies the FSM is idle.
  assign accept          = in_if.in_valid && in_ready_q;
  assign in_if.in_ready  = in_ready_q;
  assign shreg_shifted   = shreg_q >> 1;

  parx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (accept),
    .bit_done (bit_done)
  );

  // tx is loaded with the level of the state being entered, so the line
  // changes in the same cycle as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx          <= PARX_IDLE_LEVEL;
      in_ready_q  <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= '0;
      bit_idx_q   <= '0;
      // NOTE: the shift register and parity are datapath-only and are always
      // reloaded on the handshake; resetting them just keeps simulation X-free.
      shreg_q     <= '0;
      parity_q    <= 1'b0;
    end else begin
      // NOTE: the default arm returns an illegal encoding to IDLE instead of
      // leaving the FSM stuck.
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q    <= in_if.in_data;
            parity_q   <= (^in_if.in_data) ^ ODD_BIT;
            bit_idx_q  <= '0;
            state_q    <= START;
            tx         <= PARX_START_BIT;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx      <= shreg_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
              state_q <= PARITY;
              tx      <= parity_q;
            end else begin
              shreg_q   <= shreg_shifted;
              tx        <= shreg_shifted[0];
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx      <= PARX_STOP_BIT;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q     <= IDLE;
            tx          <= PARX_IDLE_LEVEL;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 8'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx         <= PARX_IDLE_LEVEL;
          in_ready_q <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parx_serial_tx.sv
// Bench for parx_serial_tx. Two instances (even and odd parity) share one
// stimulus stream; every line cycle of every frame is compared with a frame
// model built from the framing rules (start, data LSB first, parity, stop).
module tb_parx_serial_tx;

  localparam int DW         = 8;
  localparam int CPB        = 4;
  localparam int FRAME_BITS = DW + 3;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;

  logic       tx_e, tx_o, busy_e, busy_o;
  logic [7:0] fs_e, fs_o;

  int vectors     = 0;
  int miscompares = 0;
  int exp_frames  = 0;

  always #5 clk = ~clk;

  parx_serial_tx_if #(.DATA_W(DW)) if_e ();
  parx_serial_tx_if #(.DATA_W(DW)) if_o ();

  assign if_e.in_data  = in_data;
  assign if_e.in_valid = in_valid;
  assign if_o.in_data  = in_data;
  assign if_o.in_valid = in_valid;

  parx_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_e (
    .clk         (clk),
    .rst         (rst),
    .in_if       (if_e),
    .tx          (tx_e),
    .busy        (busy_e),
    .frames_sent (fs_e)
  );

  parx_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_o (
    .clk         (clk),
    .rst         (rst),
    .in_if       (if_o),
    .tx          (tx_o),
    .busy        (busy_o),
    .frames_sent (fs_o)
  );

  // Line level of frame bit k (0 = start ... FRAME_BITS-1 = stop).
  function automatic logic model_bit(input logic [7:0] d, input int k, input bit odd);
    logic [7:0] s;
    if (k == 0) return 1'b0;
    if (k <= DW) begin
      s = d >> (k - 1);
      return s[0];
    end
    if (k == DW + 1) return ((($countones(d) + (odd ? 1 : 0)) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"},       8'({tx_e, tx_o}), 8'b11);
    check({tag, " in_ready"}, 8'({if_e.in_ready, if_o.in_ready}), 8'b11);
    check({tag, " busy"},     8'({busy_e, busy_o}), 8'b00);
    check({tag, " frames_e"}, fs_e, 8'(exp_frames));
    check({tag, " frames_o"}, fs_o, 8'(exp_frames));
  endtask

  // Called at a negedge with both DUTs idle. hold keeps in_valid high with
  // next_d so the next frame is accepted in the first idle cycle; toggle
  // drives random junk on the inputs while the frame is in flight.
  task automatic run_frame(input logic [7:0] d, input bit hold,
                           input logic [7:0] next_d, input bit toggle);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      check("tx_even",   8'(tx_e), 8'(model_bit(d, i / CPB, 1'b0)));
      check("tx_odd",    8'(tx_o), 8'(model_bit(d, i / CPB, 1'b1)));
      check("ready_low", 8'({if_e.in_ready, if_o.in_ready}), 8'b00);
      check("busy_high", 8'({busy_e, busy_o}), 8'b11);
      if (hold) begin
        in_valid = 1'b1;
        in_data  = next_d;
      end else if (toggle) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    exp_frames++;
    check_idle("frame_end");
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] nd;
    bit         hold;
    bit         tog;
    int         gap;

    // Reset held 3 cycles with a word offered: reset must win.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Abort during the 3rd data bit (frame bit 3, second cycle).
    d        = 8'($urandom);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 3 * CPB + 2; i++) begin
      @(negedge clk);
      check("abort_tx_even", 8'(tx_e), 8'(model_bit(d, i / CPB, 1'b0)));
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort_recover");

    // Directed frames: 0xA5, then 0x07 with junk on the inputs mid-frame.
    run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_idle("gap_a5");
    run_frame(8'h07, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_idle("gap_07");

    // Back-to-back: in_valid held high across 0x00 then 0xFF.
    run_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    run_frame(8'hFF, 1'b0, 8'h00, 1'b0);

    // 256 random frames: wraps frames_sent, random gaps and back-to-back.
    d = 8'($urandom);
    for (int f = 0; f < 256; f++) begin
      hold = ($urandom_range(0, 3) == 0);
      nd   = 8'($urandom);
      tog  = 1'($urandom);
      run_frame(d, hold, nd, tog);
      if (!hold) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle("gap");
        end
      end
      d = nd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
